// File: rtl/noc_sequencer_if.sv
// Control/status bundle between the NoC sequencer (master) and the simulation fabric (slave).
interface noc_sequencer_if #(
  parameter int NUM_ROUTERS = 4,
  parameter int ROUTER_BITS = 2,
  parameter int OP_BITS     = 4,
  parameter int CYCLE_BITS  = 16
);
  logic                           start;
  logic                           step_mode;
  logic                           step;
  logic [CYCLE_BITS-1:0]          max_cycle;
  logic [NUM_ROUTERS-1:0]         rt_valid;
  logic [NUM_ROUTERS-1:0]         fill_req;
  logic [NUM_ROUTERS-1:0]         router_done;
  logic [NUM_ROUTERS-1:0]         traffic_empty;
  logic [NUM_ROUTERS*OP_BITS-1:0] router_op;
  logic [NUM_ROUTERS*OP_BITS-1:0] traffic_op;
  logic [ROUTER_BITS-1:0]         rt_dst;
  logic [CYCLE_BITS-1:0]          fill_idx;
  logic [CYCLE_BITS-1:0]          in_cycle;
  logic                           busy;
  logic                           finished;
  logic                           timeout;

  modport master (
    input  start, step_mode, step, max_cycle, rt_valid, fill_req, router_done, traffic_empty,
    output router_op, traffic_op, rt_dst, fill_idx, in_cycle, busy, finished, timeout
  );

  modport slave (
    output start, step_mode, step, max_cycle, rt_valid, fill_req, router_done, traffic_empty,
    input  router_op, traffic_op, rt_dst, fill_idx, in_cycle, busy, finished, timeout
  );
endinterface

// File: rtl/noc_sequencer.sv
// Bring-up and run-loop sequencer for the NoC simulation fabric; drives per-router and
// per-traffic-source op codes, with cycle-limit timeout, drain detection and single-step.
//
// state          | meaning
// ---------------+---------------------------------------------------------------
// S_IDLE         | waiting for start, all ops NOP
// S_INIT         | router Init broadcast
// S_LOAD_RT      | routing-table load, one destination (rt_dst) per clock
// S_INIT_TRAFFIC | traffic-source Init broadcast
// S_FILL         | traffic fill while any source requests, then one NOP clock
// S_STAGE        | LoadStaging on entry; in step mode holds with NOP until step
// S_PH0          | Phase0 broadcast
// S_PH1          | Phase1 broadcast, simulated cycle completes here
// S_FINISH       | drained and/or timed out, waiting for a new start
module noc_sequencer #(
  parameter int NUM_ROUTERS = 4,
  parameter int ROUTER_BITS = 2,
  parameter int OP_BITS     = 4,
  parameter int CYCLE_BITS  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  noc_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_LOAD_RT,
    S_INIT_TRAFFIC,
    S_FILL,
    S_STAGE,
    S_PH0,
    S_PH1,
    S_FINISH
  } state_t;

  localparam int OPW = NUM_ROUTERS * OP_BITS;

  localparam logic [OP_BITS-1:0] R_INIT         = OP_BITS'(1);
  localparam logic [OP_BITS-1:0] R_LOAD_RT      = OP_BITS'(2);
  localparam logic [OP_BITS-1:0] R_LOAD_STAGING = OP_BITS'(3);
  localparam logic [OP_BITS-1:0] R_PHASE0       = OP_BITS'(4);
  localparam logic [OP_BITS-1:0] R_PHASE1       = OP_BITS'(5);
  localparam logic [OP_BITS-1:0] T_INIT         = OP_BITS'(1);
  localparam logic [OP_BITS-1:0] T_FILL         = OP_BITS'(2);

  localparam logic [NUM_ROUTERS-1:0] ALL_ON  = {NUM_ROUTERS{1'b1}};
  localparam logic [ROUTER_BITS-1:0] RT_ONE  = ROUTER_BITS'(1);
  localparam logic [ROUTER_BITS-1:0] RT_LAST = ROUTER_BITS'(NUM_ROUTERS - 1);
  localparam logic [CYCLE_BITS-1:0]  CYC_ONE = CYCLE_BITS'(1);

  state_t                 state_q, state_d;
  logic [OPW-1:0]         router_op_q, router_op_d;
  logic [OPW-1:0]         traffic_op_q, traffic_op_d;
  logic [ROUTER_BITS-1:0] rt_dst_q, rt_dst_d;
  logic [CYCLE_BITS-1:0]  fill_idx_q, fill_idx_d;
  logic [CYCLE_BITS-1:0]  in_cycle_q, in_cycle_d;
  logic                   busy_q, busy_d;
  logic                   finished_q, finished_d;
  logic                   timeout_q, timeout_d;
  logic                   fill_last_q, fill_last_d;
  logic                   drained;
  logic                   cycle_limit;

  function automatic logic [OPW-1:0] fan_op(input logic [OP_BITS-1:0] op,
                                            input logic [NUM_ROUTERS-1:0] mask);
    logic [OPW-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_ROUTERS; i++) begin
      if (mask[i]) v[i*OP_BITS +: OP_BITS] = op;
    end
    return v;
  endfunction

  assign drained     = (&bus.router_done) && (&bus.traffic_empty);
  assign cycle_limit = (bus.max_cycle != '0) && ((in_cycle_q + CYC_ONE) == bus.max_cycle);

  // Ops are computed for the state being entered, so each op is visible for the
  // one clock that follows the transition edge.
  always_comb begin
    state_d      = state_q;
    router_op_d  = '0;
    traffic_op_d = '0;
    rt_dst_d     = rt_dst_q;
    fill_idx_d   = fill_idx_q;
    in_cycle_d   = in_cycle_q;
    finished_d   = finished_q;
    timeout_d    = timeout_q;
    fill_last_d  = 1'b0;

    unique case (state_q)
      S_IDLE, S_FINISH: begin
        if (bus.start) begin
          state_d     = S_INIT;
          router_op_d = fan_op(R_INIT, ALL_ON);
          rt_dst_d    = '0;
          fill_idx_d  = '0;
          in_cycle_d  = '0;
          finished_d  = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      S_INIT: begin
        state_d     = S_LOAD_RT;
        router_op_d = fan_op(R_LOAD_RT, bus.rt_valid);
      end
      S_LOAD_RT: begin
        rt_dst_d = rt_dst_q + RT_ONE;
        if (rt_dst_q == RT_LAST) begin
          state_d      = S_INIT_TRAFFIC;
          traffic_op_d = fan_op(T_INIT, ALL_ON);
        end else begin
          router_op_d = fan_op(R_LOAD_RT, bus.rt_valid);
        end
      end
      S_INIT_TRAFFIC: begin
        state_d      = S_FILL;
        traffic_op_d = fan_op(T_FILL, bus.fill_req);
        fill_last_d  = (bus.fill_req == '0);
      end
      S_FILL: begin
        // fill_last_q marks that the clock just shown was the all-NOP closing clock.
        if (fill_last_q) begin
          state_d     = S_STAGE;
          router_op_d = fan_op(R_LOAD_STAGING, ALL_ON);
        end else begin
          fill_idx_d   = fill_idx_q + CYC_ONE;
          traffic_op_d = fan_op(T_FILL, bus.fill_req);
          fill_last_d  = (bus.fill_req == '0);
        end
      end
      S_STAGE: begin
        if (!(bus.step_mode && !bus.step)) begin
          state_d     = S_PH0;
          router_op_d = fan_op(R_PHASE0, ALL_ON);
        end
      end
      S_PH0: begin
        state_d     = S_PH1;
        router_op_d = fan_op(R_PHASE1, ALL_ON);
      end
      S_PH1: begin
        in_cycle_d = in_cycle_q + CYC_ONE;
        if (drained || cycle_limit) begin
          state_d    = S_FINISH;
          finished_d = finished_q | drained;
          timeout_d  = timeout_q | cycle_limit;
        end else begin
          state_d     = S_STAGE;
          router_op_d = fan_op(R_LOAD_STAGING, ALL_ON);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      router_op_q  <= '0;
      traffic_op_q <= '0;
      rt_dst_q     <= '0;
      fill_idx_q   <= '0;
      in_cycle_q   <= '0;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
      timeout_q    <= 1'b0;
      fill_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      router_op_q  <= router_op_d;
      traffic_op_q <= traffic_op_d;
      rt_dst_q     <= rt_dst_d;
      fill_idx_q   <= fill_idx_d;
      in_cycle_q   <= in_cycle_d;
      busy_q       <= busy_d;
      finished_q   <= finished_d;
      timeout_q    <= timeout_d;
      fill_last_q  <= fill_last_d;
    end
  end

  assign bus.router_op  = router_op_q;
  assign bus.traffic_op = traffic_op_q;
  assign bus.rt_dst     = rt_dst_q;
  assign bus.fill_idx   = fill_idx_q;
  assign bus.in_cycle   = in_cycle_q;
  assign bus.busy       = busy_q;
  assign bus.finished   = finished_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_noc_sequencer.sv
// Directed bench for noc_sequencer: bring-up, fill, drain, timeout, step mode and reset.
module tb_noc_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  noc_sequencer_if #(.NUM_ROUTERS(4), .ROUTER_BITS(2), .OP_BITS(4), .CYCLE_BITS(16)) bus ();

  noc_sequencer #(.NUM_ROUTERS(4), .ROUTER_BITS(2), .OP_BITS(4), .CYCLE_BITS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.router_op, bus.traffic_op, bus.rt_dst, bus.fill_idx, bus.in_cycle,
         bus.busy, bus.finished, bus.timeout} !== 69'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", {bus.router_op, bus.traffic_op, bus.rt_dst,
               bus.fill_idx, bus.in_cycle, bus.busy, bus.finished, bus.timeout});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.router_op !== 16'h0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start: router_op=%h busy=%b want 0/0", bus.router_op, bus.busy);
    end
  endtask

  task automatic test_init_load();
    bus.rt_valid = 4'b1011;
    bus.fill_req = 4'b0011;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.router_op !== 16'h1111) begin
      failures++; $display("FAIL init_op: got %h want 1111", bus.router_op);
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.traffic_op !== 16'h0) begin
      failures++; $display("FAIL init_busy: busy=%b traffic_op=%h want 1/0000", bus.busy, bus.traffic_op);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus.router_op !== 16'h2022) begin
        failures++; $display("FAIL load_rt_op[%0d]: got %h want 2022", k, bus.router_op);
      end
      checks++;
      if (bus.rt_dst !== 2'(k)) begin
        failures++; $display("FAIL load_rt_dst[%0d]: got %0d want %0d", k, bus.rt_dst, k);
      end
    end
  endtask

  task automatic test_fill();
    tick();
    checks++;
    if (bus.traffic_op !== 16'h1111 || bus.router_op !== 16'h0) begin
      failures++; $display("FAIL traffic_init: traffic_op=%h router_op=%h want 1111/0000", bus.traffic_op, bus.router_op);
    end
    for (int f = 0; f < 2; f++) begin
      tick();
      if (f == 1) bus.fill_req = 4'b0000;
      checks++;
      if (bus.traffic_op !== 16'h0022 || bus.fill_idx !== 16'(f)) begin
        failures++; $display("FAIL fill[%0d]: traffic_op=%h fill_idx=%0d want 0022/%0d", f, bus.traffic_op, bus.fill_idx, f);
      end
    end
    tick();
    checks++;
    if (bus.traffic_op !== 16'h0 || bus.router_op !== 16'h0 || bus.fill_idx !== 16'd2) begin
      failures++; $display("FAIL fill_nop: traffic_op=%h router_op=%h fill_idx=%0d want 0000/0000/2", bus.traffic_op, bus.router_op, bus.fill_idx);
    end
    tick();
    checks++;
    if (bus.router_op !== 16'h3333 || bus.traffic_op !== 16'h0) begin
      failures++; $display("FAIL first_stage: router_op=%h traffic_op=%h want 3333/0000", bus.router_op, bus.traffic_op);
    end
  endtask

  task automatic test_drain();
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (bus.router_op !== 16'h3333 || bus.in_cycle !== 16'(c)) begin
        failures++; $display("FAIL drain_stage[%0d]: router_op=%h in_cycle=%0d want 3333/%0d", c, bus.router_op, bus.in_cycle, c);
      end
      if (c == 2) bus.start = 1'b1;
      if (c == 4) bus.router_done = 4'hF;
      if (c == 5) bus.traffic_empty = 4'hF;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.router_op !== 16'h4444) begin
        failures++; $display("FAIL drain_ph0[%0d]: got %h want 4444", c, bus.router_op);
      end
      tick();
      checks++;
      if (bus.router_op !== 16'h5555 || bus.in_cycle !== 16'(c)) begin
        failures++; $display("FAIL drain_ph1[%0d]: router_op=%h in_cycle=%0d want 5555/%0d", c, bus.router_op, bus.in_cycle, c);
      end
      tick();
    end
    checks++;
    if (bus.finished !== 1'b1 || bus.timeout !== 1'b0 || bus.busy !== 1'b0 || bus.in_cycle !== 16'd6) begin
      failures++; $display("FAIL drain_done: finished=%b timeout=%b busy=%b in_cycle=%0d want 1/0/0/6", bus.finished, bus.timeout, bus.busy, bus.in_cycle);
    end
    tick();
    tick();
    checks++;
    if (bus.router_op !== 16'h0 || bus.finished !== 1'b1 || bus.in_cycle !== 16'd6) begin
      failures++; $display("FAIL finish_hold: router_op=%h finished=%b in_cycle=%0d want 0000/1/6", bus.router_op, bus.finished, bus.in_cycle);
    end
  endtask

  task automatic test_timeout();
    bus.router_done   = 4'h0;
    bus.traffic_empty = 4'h0;
    bus.max_cycle     = 16'd3;
    bus.rt_valid      = 4'b1111;
    bus.fill_req      = 4'b0000;
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.router_op !== 16'h1111 || bus.finished !== 1'b0 || bus.in_cycle !== 16'd0 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL restart: router_op=%h finished=%b in_cycle=%0d busy=%b want 1111/0/0/1", bus.router_op, bus.finished, bus.in_cycle, bus.busy);
    end
    repeat (4) tick();
    checks++;
    if (bus.router_op !== 16'h2222 || bus.rt_dst !== 2'd3) begin
      failures++; $display("FAIL to_last_rt: router_op=%h rt_dst=%0d want 2222/3", bus.router_op, bus.rt_dst);
    end
    tick();
    tick();
    checks++;
    if (bus.traffic_op !== 16'h0 || bus.fill_idx !== 16'd0) begin
      failures++; $display("FAIL to_empty_fill: traffic_op=%h fill_idx=%0d want 0000/0", bus.traffic_op, bus.fill_idx);
    end
    tick();
    checks++;
    if (bus.router_op !== 16'h3333) begin
      failures++; $display("FAIL to_stage: got %h want 3333", bus.router_op);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      tick();
      checks++;
      if (bus.router_op !== 16'h5555 || bus.in_cycle !== 16'(c) || bus.busy !== 1'b1) begin
        failures++; $display("FAIL to_ph1[%0d]: router_op=%h in_cycle=%0d busy=%b want 5555/%0d/1", c, bus.router_op, bus.in_cycle, bus.busy, c);
      end
      tick();
      if (c < 2) begin
        checks++;
        if (bus.router_op !== 16'h3333 || bus.timeout !== 1'b0) begin
          failures++; $display("FAIL to_early[%0d]: router_op=%h timeout=%b want 3333/0", c, bus.router_op, bus.timeout);
        end
      end
    end
    checks++;
    if (bus.timeout !== 1'b1 || bus.finished !== 1'b0 || bus.busy !== 1'b0 || bus.in_cycle !== 16'd3 || bus.router_op !== 16'h0) begin
      failures++; $display("FAIL to_done: timeout=%b finished=%b busy=%b in_cycle=%0d router_op=%h want 1/0/0/3/0000", bus.timeout, bus.finished, bus.busy, bus.in_cycle, bus.router_op);
    end
  endtask

  task automatic test_both_flags();
    bus.max_cycle     = 16'd1;
    bus.router_done   = 4'hF;
    bus.traffic_empty = 4'hF;
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.timeout !== 1'b0 || bus.finished !== 1'b0) begin
      failures++; $display("FAIL both_clear: timeout=%b finished=%b want 0/0", bus.timeout, bus.finished);
    end
    repeat (7) tick();
    checks++;
    if (bus.router_op !== 16'h3333) begin
      failures++; $display("FAIL both_stage: got %h want 3333", bus.router_op);
    end
    repeat (3) tick();
    checks++;
    if (bus.finished !== 1'b1 || bus.timeout !== 1'b1 || bus.in_cycle !== 16'd1 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL both_done: finished=%b timeout=%b in_cycle=%0d busy=%b want 1/1/1/0", bus.finished, bus.timeout, bus.in_cycle, bus.busy);
    end
  endtask

  task automatic test_step();
    bus.max_cycle     = 16'd0;
    bus.router_done   = 4'h0;
    bus.traffic_empty = 4'h0;
    bus.rt_valid      = 4'b0000;
    bus.step_mode     = 1'b1;
    bus.step          = 1'b0;
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.router_op !== 16'h0 || bus.rt_dst !== 2'd0 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL step_rt_masked: router_op=%h rt_dst=%0d busy=%b want 0000/0/1", bus.router_op, bus.rt_dst, bus.busy);
    end
    repeat (6) tick();
    checks++;
    if (bus.router_op !== 16'h3333) begin
      failures++; $display("FAIL step_stage_entry: got %h want 3333", bus.router_op);
    end
    for (int p = 1; p <= 3; p++) begin
      for (int w = 0; w < 7; w++) begin
        tick();
        checks++;
        if (bus.router_op !== 16'h0 || bus.in_cycle !== 16'(p - 1) || bus.busy !== 1'b1) begin
          failures++; $display("FAIL step_wait[%0d.%0d]: router_op=%h in_cycle=%0d busy=%b want 0000/%0d/1", p, w, bus.router_op, bus.in_cycle, bus.busy, p - 1);
        end
      end
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      checks++;
      if (bus.router_op !== 16'h4444) begin
        failures++; $display("FAIL step_ph0[%0d]: got %h want 4444", p, bus.router_op);
      end
      tick();
      tick();
      checks++;
      if (bus.router_op !== 16'h3333 || bus.in_cycle !== 16'(p)) begin
        failures++; $display("FAIL step_advance[%0d]: router_op=%h in_cycle=%0d want 3333/%0d", p, bus.router_op, bus.in_cycle, p);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    checks++;
    if (bus.router_op !== 16'h4444) begin
      failures++; $display("FAIL rst_pre_ph0: got %h want 4444", bus.router_op);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.router_op, bus.traffic_op, bus.rt_dst, bus.fill_idx, bus.in_cycle,
         bus.busy, bus.finished, bus.timeout} !== 69'h0) begin
      failures++;
      $display("FAIL rst_async: got %h want 0", {bus.router_op, bus.traffic_op, bus.rt_dst,
               bus.fill_idx, bus.in_cycle, bus.busy, bus.finished, bus.timeout});
    end
    tick();
    rst_n         = 1'b1;
    bus.step_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.router_op !== 16'h0 || bus.traffic_op !== 16'h0 || bus.busy !== 1'b0) begin
        failures++; $display("FAIL rst_idle[%0d]: router_op=%h traffic_op=%h busy=%b want 0000/0000/0", i, bus.router_op, bus.traffic_op, bus.busy);
      end
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.router_op !== 16'h1111) begin
      failures++; $display("FAIL rst_restart: got %h want 1111", bus.router_op);
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.start         = 1'b0;
    bus.step_mode     = 1'b0;
    bus.step          = 1'b0;
    bus.max_cycle     = 16'd0;
    bus.rt_valid      = 4'b0000;
    bus.fill_req      = 4'b0000;
    bus.router_done   = 4'h0;
    bus.traffic_empty = 4'h0;

    test_reset();
    test_init_load();
    test_fill();
    test_drain();
    test_timeout();
    test_both_flags();
    test_step();
    test_reset_mid_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
